pb_debounce_multi: RTL and testbench

//  N-channel push-button conditioner: synchronises raw inputs, debounces them with a

---
 rtl/pb_debounce_multi_pkg.sv | 15 +
 rtl/pb_debounce_multi_tick_gen.sv | 38 +++
 rtl/pb_debounce_multi.sv | 89 ++++++++
 tb/tb_pb_debounce_multi.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pb_debounce_multi_pkg.sv
// pb_debounce_multi_pkg: shared defaults and counter-width helpers for the push-button conditioner.
package pb_debounce_multi_pkg;

   localparam int DEF_CLK_FREQ  = 50_000_000;
   localparam int DEF_SAMPLE_HZ = 1_000;

   function automatic int cw(input int max_v);
      return (max_v < 1) ? 1 : $clog2(max_v + 1);
   endfunction

   function automatic int div_of(input int clk_freq, input int sample_hz);
      return (sample_hz < 1) ? 0 : clk_freq / sample_hz;
   endfunction

endpackage

// File: rtl/pb_debounce_multi_tick_gen.sv
// tick_gen: divides clk into a one-cycle sample-enable pulse every CLK_FREQ/SAMPLE_HZ cycles.
module tick_gen
   import pb_debounce_multi_pkg::*;
#(
   parameter int CLK_FREQ  = DEF_CLK_FREQ,
   parameter int SAMPLE_HZ = DEF_SAMPLE_HZ
)(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV_RAW = div_of(CLK_FREQ, SAMPLE_HZ);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CW      = cw(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // tick is registered so it stays low during reset, even when DIV=1
   always_comb begin
      tick_d = (cnt_q == CW'(DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi: N-channel synchronise/debounce with clean level and rise/fall/long-press pulses.
module pb_debounce_multi
   import pb_debounce_multi_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int SAMPLE_HZ  = DEF_SAMPLE_HZ,
   parameter int N_CH       = 4,
   parameter int STABLE_CNT = 10,
   parameter int LONG_CNT   = 1_000,
   parameter int ACTIVE_LOW = 0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] pb_level,
   output logic [N_CH-1:0] pb_rise,
   output logic [N_CH-1:0] pb_fall,
   output logic [N_CH-1:0] pb_long,
   output logic            tick
);

   localparam int   SW  = cw(STABLE_CNT - 1);
   localparam int   HW  = cw(LONG_CNT);
   localparam logic INV = (ACTIVE_LOW != 0);

   if (div_of(CLK_FREQ, SAMPLE_HZ) < 1 || STABLE_CNT < 1 || LONG_CNT <= STABLE_CNT || N_CH < 1)
   begin : g_bad_params
      $error("pb_debounce_multi: need DIV>=1, STABLE_CNT>=1, LONG_CNT>STABLE_CNT, N_CH>=1");
   end

   tick_gen #(
      .CLK_FREQ  (CLK_FREQ),
      .SAMPLE_HZ (SAMPLE_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [1:0]    sync_q, sync_d;
      logic [SW-1:0] stab_q, stab_d;
      logic [HW-1:0] hold_q, hold_d;
      logic          level_q, level_d;
      logic          rise_q, rise_d;
      logic          fall_q, fall_d;
      logic          long_q, long_d;
      logic          s, flip;

      // a differing sample that completes the stable run flips the level and resets the run
      always_comb begin
         sync_d  = {sync_q[0], pb_in[c] ^ INV};
         s       = sync_q[1];
         flip    = tick && (s != level_q) && (stab_q == SW'(STABLE_CNT - 1));
         stab_d  = !tick ? stab_q : ((s == level_q) || flip) ? '0 : stab_q + 1'b1;
         level_d = flip ? s : level_q;
         rise_d  = flip && s;
         fall_d  = flip && !s;
         hold_d  = !level_q ? '0 : (tick && hold_q != HW'(LONG_CNT)) ? hold_q + 1'b1 : hold_q;
         long_d  = level_q && tick && (hold_q == HW'(LONG_CNT - 1));
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q  <= '0;
            stab_q  <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            long_q  <= long_d;
         end
      end

      assign pb_level[c] = level_q;
      assign pb_rise[c]  = rise_q;
      assign pb_fall[c]  = fall_q;
      assign pb_long[c]  = long_q;
   end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// tb_pb_debounce_multi: scoreboard bench running active-high and active-low instances side by side.
module tb_pb_debounce_multi;

   localparam int DIV = 10;

   typedef struct {
      int         cyc;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] lng;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] pb_in = 2'b11;
   logic [1:0] pb_in_n;
   logic [1:0] lvl_a, rise_a, fall_a, long_a, lvl_b, rise_b, fall_b, long_b;
   logic       tick_a, tick_b;

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   int  ptr[2] = '{0, 0};
   ev_t exp_q[$];

   assign pb_in_n = ~pb_in;

   always #5 clk = ~clk;

   pb_debounce_multi #(
      .CLK_FREQ(1000), .SAMPLE_HZ(100), .N_CH(2), .STABLE_CNT(3), .LONG_CNT(8), .ACTIVE_LOW(0)
   ) dut_a (
      .clk(clk), .rst(rst), .pb_in(pb_in), .pb_level(lvl_a), .pb_rise(rise_a),
      .pb_fall(fall_a), .pb_long(long_a), .tick(tick_a)
   );

   pb_debounce_multi #(
      .CLK_FREQ(1000), .SAMPLE_HZ(100), .N_CH(2), .STABLE_CNT(3), .LONG_CNT(8), .ACTIVE_LOW(1)
   ) dut_b (
      .clk(clk), .rst(rst), .pb_in(pb_in_n), .pb_level(lvl_b), .pb_rise(rise_b),
      .pb_fall(fall_b), .pb_long(long_b), .tick(tick_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   // cycle (edges since reset release) on which the pulse from the n-th sampling tick is visible
   function automatic int t_evt(input int c0, input int n);
      return DIV * ((c0 + 2 + DIV - 1) / DIV + n - 1) + 1;
   endfunction

   function automatic void push_ev(input int c, input logic [1:0] r, input logic [1:0] f,
                                   input logic [1:0] l);
      int  i = 0;
      ev_t e;
      while (i < exp_q.size() && exp_q[i].cyc < c) i++;
      if (i < exp_q.size() && exp_q[i].cyc == c) begin
         e = exp_q[i];
         e.rise |= r;
         e.fall |= f;
         e.lng  |= l;
         exp_q[i] = e;
      end else begin
         e.cyc  = c;
         e.rise = r;
         e.fall = f;
         e.lng  = l;
         exp_q.insert(i, e);
      end
   endfunction

   task automatic mon(input int d, input logic [1:0] r, input logic [1:0] f, input logic [1:0] l);
      ev_t e;
      while (ptr[d] < exp_q.size() && exp_q[ptr[d]].cyc < cyc) begin
         chk($sformatf("missed_ev%0d", d), cyc, exp_q[ptr[d]].cyc);
         ptr[d]++;
      end
      if ((r | f | l) != 2'b00) begin
         if (ptr[d] < exp_q.size() && exp_q[ptr[d]].cyc == cyc) begin
            e = exp_q[ptr[d]];
            chk($sformatf("rise%0d", d), int'(r), int'(e.rise));
            chk($sformatf("fall%0d", d), int'(f), int'(e.fall));
            chk($sformatf("long%0d", d), int'(l), int'(e.lng));
            ptr[d]++;
         end else begin
            chk($sformatf("unexpected_ev%0d", d), int'({r, f, l}), 0);
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_a", int'({lvl_a, rise_a, fall_a, long_a, tick_a}), 0);
         chk("rst_out_b", int'({lvl_b, rise_b, fall_b, long_b, tick_b}), 0);
      end else begin
         chk("tick", int'({tick_a, tick_b}), (cyc % DIV == 0 && cyc != 0) ? 3 : 0);
         mon(0, rise_a, fall_a, long_a);
         mon(1, rise_b, fall_b, long_b);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_lvl(input string tag, input logic [1:0] mask, input logic [1:0] val,
                           input int budget);
      int n = 0;
      while (n < budget && (lvl_a & mask) != val) begin
         @(negedge clk);
         n++;
      end
      chk(tag, int'(lvl_a & mask), int'(val));
      chk({tag, "_b"}, int'(lvl_b & mask), int'(val));
   endtask

   task automatic drive(input logic [1:0] v);
      @(negedge clk);
      pb_in = v;
   endtask

   initial begin
      int c0;
      // reset with inputs pressed: nothing may come out, no ticks
      idle(25);
      chk("rst_level", int'(lvl_a | lvl_b), 0);
      pb_in = 2'b00;
      idle(2);
      rst = 1'b1;
      idle(30);

      // clean press on ch0, then release before a long press can form
      drive(2'b01);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b01, 2'b00, 2'b00);
      wait_lvl("press_ch0", 2'b11, 2'b01, 33);
      drive(2'b00);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b00, 2'b01, 2'b00);
      wait_lvl("release_ch0", 2'b11, 2'b00, 33);
      idle(20);

      // bounce: two high samples, one low, five times -> never three in a row
      while (cyc % DIV != 5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         pb_in = 2'b01;
         idle(2 * DIV);
         pb_in = 2'b00;
         idle(DIV);
      end
      chk("bounce_level", int'(lvl_a[0]), 0);
      chk("bounce_level_b", int'(lvl_b[0]), 0);
      idle(30);

      // long press on ch1: one long pulse 8 ticks after rise, held 12 ticks
      drive(2'b10);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b10, 2'b00, 2'b00);
      push_ev(t_evt(c0, 11), 2'b00, 2'b00, 2'b10);
      wait_lvl("press_ch1", 2'b10, 2'b10, 33);
      idle(12 * DIV);
      chk("hold_level", int'(lvl_a), 2);
      drive(2'b00);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b00, 2'b10, 2'b00);
      wait_lvl("release_ch1", 2'b10, 2'b00, 33);
      idle(20);

      // both channels in the same cycle
      drive(2'b11);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b11, 2'b00, 2'b00);
      wait_lvl("press_both", 2'b11, 2'b11, 33);
      idle(20);
      drive(2'b00);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b00, 2'b11, 2'b00);
      wait_lvl("release_both", 2'b11, 2'b00, 33);
      idle(20);

      // reset mid-hold at hold count 5, input kept pressed across release
      drive(2'b10);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b10, 2'b00, 2'b00);
      wait_lvl("press_pre_rst", 2'b10, 2'b10, 33);
      idle(5 * DIV + 2);
      chk("pre_rst_level", int'(lvl_a), 2);
      @(posedge clk);
      #2;
      exp_q.delete();
      ptr = '{0, 0};
      rst = 1'b0;
      #1;
      chk("async_rst_a", int'({lvl_a, rise_a, fall_a, long_a, tick_a}), 0);
      chk("async_rst_b", int'({lvl_b, rise_b, fall_b, long_b, tick_b}), 0);
      idle(5);
      rst = 1'b1;
      push_ev(t_evt(0, 3), 2'b10, 2'b00, 2'b00);
      push_ev(t_evt(0, 11), 2'b00, 2'b00, 2'b10);
      wait_lvl("press_post_rst", 2'b10, 2'b10, 40);
      idle(10 * DIV);
      drive(2'b00);
      c0 = cyc;
      push_ev(t_evt(c0, 3), 2'b00, 2'b10, 2'b00);
      wait_lvl("release_post_rst", 2'b10, 2'b00, 33);
      idle(30);

      chk("sb_drain_a", ptr[0], exp_q.size());
      chk("sb_drain_b", ptr[1], exp_q.size());
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
